// File: rtl/binary_to_ternary_converter_pkg.sv
// ============================================================================
// Module : binary_to_ternary_converter_pkg
// Brief  : Shared trit encodings, FSM state codes and sizing helper.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package binary_to_ternary_converter_pkg;

  localparam logic [1:0] TRIT_ZERO = 2'b00;
  localparam logic [1:0] TRIT_ONE  = 2'b01;
  localparam logic [1:0] TRIT_TWO  = 2'b10;
  localparam logic [1:0] TRIT_BAD  = 2'b11;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CONV = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // Counter width for N digits; never narrower than one bit.
  function automatic int clog2_min1(input int n);
    int w;
    w = 0;
    while ((1 << w) < n) w++;
    return (w < 1) ? 1 : w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/binary_to_ternary_converter_div3.sv
// ============================================================================
// Module : ternary_div3
// Brief  : Combinational unsigned divide-by-3, quotient and remainder (0..2).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ternary_div3 #(
  parameter int W = 7
) (
  input  logic [W-1:0] din,
  output logic [W-1:0] quot,
  output logic [1:0]   rem
);

  logic [2:0] acc;

  // Restoring long division: the partial remainder never exceeds 2, so 3 bits suffice.
  always_comb begin
    acc  = 3'd0;
    quot = '0;
    for (int i = W - 1; i >= 0; i--) begin
      acc = {acc[1:0], din[i]};
      if (acc >= 3'd3) begin
        quot[i] = 1'b1;
        acc     = acc - 3'd3;
      end
    end
    rem = acc[1:0];
  end

endmodule

`default_nettype wire

// File: rtl/binary_to_ternary_converter.sv
// ============================================================================
// Module : binary_to_ternary_converter
// Brief  : Iterative binary to unbalanced-ternary converter, one trit per clock.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module binary_to_ternary_converter
  import binary_to_ternary_converter_pkg::*;
#(
  parameter int N = 4,
  parameter int W = 7
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   in_bin,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] out_tern,
  output logic           out_overflow
);

  localparam int CW = clog2_min1(N);

  logic [1:0]     state_q, state_d;
  logic [W-1:0]   work_q, work_d;
  logic [CW-1:0]  count_q, count_d;
  logic [2*N-1:0] out_tern_q, out_tern_d;
  logic           out_overflow_q, out_overflow_d;

  logic [W-1:0]   div_quot;
  logic [1:0]     div_rem;
  logic           last_trit;

  ternary_div3 #(.W(W)) u_div3 (
    .din  (work_q),
    .quot (div_quot),
    .rem  (div_rem)
  );

  assign last_trit = (count_q == CW'(N - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      work_q         <= '0;
      count_q        <= '0;
      out_tern_q     <= '0;
      out_overflow_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      work_q         <= work_d;
      count_q        <= count_d;
      out_tern_q     <= out_tern_d;
      out_overflow_q <= out_overflow_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (in_valid)  state_d = S_CONV;
      S_CONV:  if (last_trit) state_d = S_DONE;
      S_DONE:  if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    work_d         = work_q;
    count_d        = count_q;
    out_tern_d     = out_tern_q;
    out_overflow_d = out_overflow_q;
    if (state_q == S_IDLE && in_valid) begin
      work_d         = in_bin;
      count_d        = '0;
      out_tern_d     = {N{TRIT_ZERO}};
      out_overflow_d = 1'b0;
    end else if (state_q == S_CONV) begin
      for (int k = 0; k < N; k++) begin
        if (count_q == CW'(k)) out_tern_d[2*k +: 2] = div_rem;
      end
      work_d  = div_quot;
      count_d = count_q + CW'(1);
      // Any quotient left after the top digit means the value did not fit in N trits.
      if (last_trit) out_overflow_d = |div_quot;
    end
  end

  always_comb begin
    in_ready     = (state_q == S_IDLE);
    out_valid    = (state_q == S_DONE);
    out_tern     = out_tern_q;
    out_overflow = out_overflow_q;
  end

endmodule

`default_nettype wire
